expr_result_checker: RTL and testbench
======================================

EXPR_RESULT_CHECKER -- requirements
Module: expr_result_checker

Interface
REQ-001 Parameter Y_W, default 90, SHALL set the width of the consumed expression result vector.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the vector count, error count and index.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 start  input  1  SHALL be a one-cycle pulse that clears results and arms a run.
REQ-006 num_vec  input  CNT_W  SHALL give the number of vectors in the run, sampled when start is accepted.
REQ-007 in_valid  input  1  SHALL mark that y_dut and y_exp carry a vector.
REQ-008 in_ready  output  1  SHALL mark that the block accepts a vector.
REQ-009 y_dut  input  Y_W  SHALL carry the result from the expression stage under test.
REQ-010 y_exp  input  Y_W  SHALL carry the expected result for the same vector.
REQ-011 done  output  1  SHALL be high while results are final.
REQ-012 pass  output  1  SHALL be high when done and err_cnt is 0.
REQ-013 err_cnt  output  CNT_W  SHALL be the number of mismatching vectors.
REQ-014 first_err_idx  output  CNT_W  SHALL be the 0-based index of the first mismatch, or all-ones if there is none.
REQ-015 signature  output  32  SHALL be the MISR signature over all accepted y_dut values.

Function
REQ-016 The FSM SHALL have three states, IDLE, RUN and DONE; in_ready = (state==RUN); done = (state==DONE).
REQ-017 A transfer SHALL occur on a cycle with in_valid && in_ready; no other cycle changes idx, err_cnt, first_err_idx or signature.
REQ-018 start in any state SHALL, on the next edge, clear idx, err_cnt and first_err_idx (to all-ones), set signature to 32'hFFFFFFFF, latch num_vec, and enter RUN; if num_vec==0, it enters DONE instead.
REQ-019 start in RUN SHALL abort the run and re-arm it; any transfer in that same cycle is discarded.
REQ-020 A transfer SHALL count as a mismatch when any bit of y_dut differs from y_exp.
REQ-021 On a mismatch, err_cnt SHALL increment, saturating at all-ones.
REQ-022 On the first mismatch of a run, first_err_idx SHALL capture the current idx.
REQ-023 A transfer SHALL update signature as {sig[30:0],0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
REQ-024 fold SHALL be the XOR of the successive 32-bit slices of y_dut, with the top slice zero-extended.
REQ-025 The transfer with idx==latched_num_vec-1 SHALL move the FSM to DONE; done SHALL rise on the next cycle (latency 1).
REQ-026 DONE SHALL hold all outputs stable until start or reset.
REQ-027 in_valid in IDLE or DONE SHALL be ignored.
REQ-028 All comparisons SHALL be unsigned bitwise; Y_W values not a multiple of 32 SHALL be handled by the zero-extension in REQ-024.

Reset
REQ-029 While rst_n is low: state=IDLE, in_ready=0, done=0, pass=0, err_cnt=0, first_err_idx=all-ones, signature=32'hFFFFFFFF, idx=0.
REQ-030 Reset asserted mid-run SHALL abandon the run, with no partial results retained.

Structure
REQ-031 Package expr_chk_pkg SHALL hold the state enum, MISR_POLY=32'h04C11DB7, MISR_SEED=32'hFFFFFFFF and the default widths.
REQ-032 The MISR and fold logic SHALL be a sub-module expr_misr32 with ports clk, rst_n, clr, en, din[Y_W] and sig[32].

Verification
REQ-033 start, num_vec=4, four matching transfers -> done one cycle after the 4th transfer, pass=1, err_cnt=0, first_err_idx=16'hFFFF.
REQ-034 num_vec=4, mismatches at idx 2 and 3 -> err_cnt=2, first_err_idx=2, pass=0.
REQ-035 num_vec=1, y_dut=0 -> signature=32'hFB3EE249.
REQ-036 num_vec=0 -> done the cycle after start, pass=1, in_ready never high.
REQ-037 in_valid toggling with gaps, num_vec=3 -> exactly 3 transfers counted; in_ready=0 in DONE.
REQ-038 rst_n low after 2 of 5 transfers -> all REQ-029 values; a new start runs from idx 0.

Source files
------------

// File: rtl/expr_chk_pkg.sv
// Shared types and constants for the expression result checker.
package expr_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  localparam int unsigned Y_W_DEF   = 90;
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/expr_misr32.sv
// 32-bit MISR compacting a wide result vector folded to 32 bits.
module expr_misr32
  import expr_chk_pkg::*;
#(
  parameter int unsigned Y_W = Y_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic [Y_W-1:0] din,
  output logic [31:0]    sig
);

  localparam int unsigned NS = (Y_W + 31) / 32;
  localparam int unsigned PW = NS * 32;

  logic [PW-1:0] padded;
  logic [31:0]   fold;
  logic [31:0]   sig_nx;

  assign padded = PW'(din);

  // XOR of all 32-bit slices; the top slice is zero-padded by the cast above
  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      fold = fold ^ padded[i*32 +: 32];
    end
  end

  assign sig_nx = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ fold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= MISR_SEED;
    end else if (clr) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= sig_nx;
    end
  end

endmodule

// File: rtl/expr_result_checker.sv
// Compares a stream of DUT results against expected values, counts errors
// and compacts the DUT results into a MISR signature.
module expr_result_checker
  import expr_chk_pkg::*;
#(
  parameter int unsigned Y_W   = Y_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   y_dut,
  input  logic [Y_W-1:0]   y_exp,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [31:0]      signature
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] num_lat;
  logic             xfer;
  logic             mismatch;
  logic             last;

  // A start in the same cycle discards any transfer
  assign xfer     = in_valid && (state == ST_RUN) && !start;
  assign mismatch = (y_dut != y_exp);
  assign last     = (idx == (num_lat - CNT_W'(1)));

  assign in_ready = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign pass     = done && (err_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = (num_vec == '0) ? ST_DONE : ST_RUN;
    end else if (xfer && last) begin
      state_nx = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      num_lat       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
    end else if (start) begin
      idx           <= '0;
      num_lat       <= num_vec;
      err_cnt       <= '0;
      first_err_idx <= '1;
    end else if (xfer) begin
      idx <= idx + CNT_W'(1);
      if (mismatch) begin
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        if (err_cnt == '0) begin
          first_err_idx <= idx;
        end
      end
    end
  end

  expr_misr32 #(
    .Y_W(Y_W)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .en   (xfer),
    .din  (y_dut),
    .sig  (signature)
  );

endmodule

// File: tb/tb_expr_result_checker.sv
// Self-checking bench for expr_result_checker: single-vector table plus
// directed multi-cycle sequences.
module tb_expr_result_checker;

  localparam int unsigned YW = 90;
  localparam int unsigned CW = 16;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_vec;
  logic          in_valid;
  logic          in_ready;
  logic [YW-1:0] y_dut;
  logic [YW-1:0] y_exp;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] first_err_idx;
  logic [31:0]   signature;

  int checks = 0;
  int passed = 0;

  logic mon_en = 1'b0;
  logic ready_seen = 1'b0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && in_ready) ready_seen = 1'b1;
  end

  expr_result_checker #(.Y_W(YW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_vec      (num_vec),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .y_dut        (y_dut),
    .y_exp        (y_exp),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .first_err_idx(first_err_idx),
    .signature    (signature)
  );

  typedef struct {
    logic [YW-1:0] d;
    logic [YW-1:0] e;
    logic [CW-1:0] x_err;
    logic [CW-1:0] x_first;
    logic [31:0]   x_sig;
    logic          x_pass;
  } vec_t;

  vec_t tbl [6];

  // Bench reference: fold bit-by-bit into position b mod 32, then shift/poly
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [YW-1:0] y);
    logic [31:0] f;
    logic [31:0] ns;
    f = '0;
    for (int b = 0; b < int'(YW); b++) f[b % 32] = f[b % 32] ^ y[b];
    ns = {s[30:0], 1'b0};
    if (s[31]) ns = ns ^ 32'h04C11DB7;
    return ns ^ f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %0h required %0h", name, act, req);
    else passed++;
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    @(negedge clk);
    start = 1'b1;
    num_vec = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [YW-1:0] d, input logic [YW-1:0] e);
    @(negedge clk);
    in_valid = 1'b1;
    y_dut = d;
    y_exp = e;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  logic [YW-1:0] pat [4];
  logic [31:0]   s;
  logic [9:0]    vpat;
  logic [YW-1:0] d;
  int            acc;

  initial begin
    rst_n = 1'b0; start = 1'b0; num_vec = '0; in_valid = 1'b0; y_dut = '0; y_exp = '0;

    tbl[0] = '{90'h0, 90'h0, 16'd0, 16'hFFFF, 32'hFB3EE249, 1'b1};
    tbl[1] = '{90'h1, 90'h1, 16'd0, 16'hFFFF, 32'hFB3EE248, 1'b1};
    tbl[2] = '{90'h1_0000_0000, 90'h1_0000_0000, 16'd0, 16'hFFFF, 32'hFB3EE248, 1'b1};
    tbl[3] = '{{90{1'b1}}, {90{1'b1}}, 16'd0, 16'hFFFF, 32'hF8C11DB6, 1'b1};
    tbl[4] = '{90'h0, 90'h1, 16'd1, 16'd0, 32'hFB3EE249, 1'b0};
    tbl[5] = '{90'h200_0000_0000_0000_0000_0000, 90'h0, 16'd1, 16'd0, 32'hF93EE249, 1'b0};

    pat[0] = 90'h123_4567_89AB_CDEF_0123_4567;
    pat[1] = 90'h3A5_5A5A_A5A5_0F0F_F0F0_1234;
    pat[2] = 90'h000_0000_0001_8000_0000_FFFF;
    pat[3] = 90'h2FF_DEAD_BEEF_CAFE_F00D_0001;

    // Reset values
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_first_err", 64'(first_err_idx), 64'hFFFF);
    chk("rst_signature", 64'(signature), 64'hFFFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-vector table
    for (int i = 0; i < 6; i++) begin
      do_start(16'd1);
      send(tbl[i].d, tbl[i].e);
      wait_done($sformatf("tbl%0d_done", i));
      chk($sformatf("tbl%0d_err", i), 64'(err_cnt), 64'(tbl[i].x_err));
      chk($sformatf("tbl%0d_first", i), 64'(first_err_idx), 64'(tbl[i].x_first));
      chk($sformatf("tbl%0d_sig", i), 64'(signature), 64'(tbl[i].x_sig));
      chk($sformatf("tbl%0d_pass", i), 64'(pass), 64'(tbl[i].x_pass));
    end

    // Four matching transfers; done exactly one cycle after the fourth
    do_start(16'd4);
    s = SEED;
    for (int i = 0; i < 3; i++) begin
      send(pat[i], pat[i]);
      s = model_step(s, pat[i]);
    end
    @(negedge clk);
    in_valid = 1'b1; y_dut = pat[3]; y_exp = pat[3];
    s = model_step(s, pat[3]);
    chk("m4_done_before", 64'(done), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("m4_done_after", 64'(done), 64'd1);
    chk("m4_pass", 64'(pass), 64'd1);
    chk("m4_err", 64'(err_cnt), 64'd0);
    chk("m4_first", 64'(first_err_idx), 64'hFFFF);
    chk("m4_sig", 64'(signature), 64'(s));

    // Mismatches at idx 2 and 3
    do_start(16'd4);
    s = SEED;
    for (int i = 0; i < 4; i++) begin
      send(pat[i], (i >= 2) ? (pat[i] ^ (90'(1) << (i * 20))) : pat[i]);
      s = model_step(s, pat[i]);
    end
    wait_done("mm_done");
    chk("mm_err", 64'(err_cnt), 64'd2);
    chk("mm_first", 64'(first_err_idx), 64'd2);
    chk("mm_pass", 64'(pass), 64'd0);
    chk("mm_sig", 64'(signature), 64'(s));

    // num_vec=0: done right after start, in_ready never asserted
    ready_seen = 1'b0;
    mon_en = 1'b1;
    do_start(16'd0);
    chk("z_done", 64'(done), 64'd1);
    chk("z_pass", 64'(pass), 64'd1);
    chk("z_sig", 64'(signature), 64'(SEED));
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    chk("z_ready_seen", 64'(ready_seen), 64'd0);

    // Gapped in_valid, three mismatching transfers, extra valids in DONE ignored
    do_start(16'd3);
    vpat = 10'b11_0110_1001;
    s = SEED;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d = 90'(i * 37 + 5) ^ (90'(i) << 70);
      in_valid = vpat[i];
      y_dut = d;
      y_exp = d ^ 90'h4;
      if (vpat[i] && acc < 3) begin
        s = model_step(s, d);
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("gap_done", 64'(done), 64'd1);
    chk("gap_in_ready", 64'(in_ready), 64'd0);
    chk("gap_err", 64'(err_cnt), 64'd3);
    chk("gap_first", 64'(first_err_idx), 64'd0);
    chk("gap_sig", 64'(signature), 64'(s));
    repeat (3) @(negedge clk);
    chk("hold_err", 64'(err_cnt), 64'd3);
    chk("hold_sig", 64'(signature), 64'(s));
    chk("hold_done", 64'(done), 64'd1);

    // Start during RUN aborts; same-cycle transfer discarded
    do_start(16'd3);
    send(pat[0], pat[0]);
    send(pat[1], pat[2]);
    chk("ab_err_pre", 64'(err_cnt), 64'd1);
    @(negedge clk);
    start = 1'b1; num_vec = 16'd2;
    in_valid = 1'b1; y_dut = pat[3]; y_exp = pat[0];
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("ab_err", 64'(err_cnt), 64'd0);
    chk("ab_first", 64'(first_err_idx), 64'hFFFF);
    chk("ab_sig", 64'(signature), 64'(SEED));
    chk("ab_in_ready", 64'(in_ready), 64'd1);
    s = SEED;
    for (int i = 0; i < 2; i++) begin
      send(pat[i], pat[i]);
      s = model_step(s, pat[i]);
    end
    wait_done("ab_done");
    chk("ab_pass", 64'(pass), 64'd1);
    chk("ab_sig_end", 64'(signature), 64'(s));

    // Reset mid-run after 2 of 5 transfers
    do_start(16'd5);
    send(pat[0], pat[1]);
    send(pat[2], pat[2]);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_pass", 64'(pass), 64'd0);
    chk("mr_err", 64'(err_cnt), 64'd0);
    chk("mr_first", 64'(first_err_idx), 64'hFFFF);
    chk("mr_sig", 64'(signature), 64'(SEED));
    @(negedge clk);
    rst_n = 1'b1;
    do_start(16'd2);
    s = SEED;
    send(pat[3], pat[3]);
    s = model_step(s, pat[3]);
    chk("mr2_done_mid", 64'(done), 64'd0);
    send(pat[1], pat[0]);
    s = model_step(s, pat[1]);
    wait_done("mr2_done");
    chk("mr2_err", 64'(err_cnt), 64'd1);
    chk("mr2_first", 64'(first_err_idx), 64'd1);
    chk("mr2_sig", 64'(signature), 64'(s));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
